// File: rtl/dcsk_tx_fsm.sv
// DCSK transmitter: each bit sends a chaotic reference half, then the same samples again,
// negated for a 0 bit. Define DCSK_TX_SAT_NEG_EN to saturate negation of the most negative sample.
module dcsk_tx_fsm #(
    parameter int unsigned WORD_W   = 8,
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic                       Clk,
    input  logic                       N_Rst,
    input  logic                       Valid,
    input  logic [WORD_W-1:0]          Data_In,
    output logic                       Ready,
    input  logic [4:0]                 Spread_Factor,
    input  logic signed [SAMPLE_W-1:0] Chaos_Sample,
    output logic                       Chaos_Req,
    output logic signed [SAMPLE_W-1:0] Tx_Sample,
    output logic                       Tx_Valid,
    output logic                       Tx_Ref
);

    localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StRef, StData} state_e;

    state_e                      state_q, state_d;
    logic [WORD_W-1:0]           word_q, word_d;
    logic [4:0]                  sf_q, sf_d;
    logic [4:0]                  cnt_q, cnt_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic signed [SAMPLE_W-1:0]  tx_sample_q, tx_sample_d;
    logic                        tx_valid_q, tx_valid_d;
    logic                        tx_ref_q, tx_ref_d;

    logic signed [SAMPLE_W-1:0]  ref_buf [32];
    logic signed [SAMPLE_W-1:0]  buf_rd;
    logic signed [SAMPLE_W-1:0]  buf_neg;
    logic                        cur_bit;
    logic                        half_done;
    logic                        last_bit;

    assign buf_rd    = ref_buf[cnt_q];
    assign cur_bit   = word_q[bit_q];
    assign half_done = (cnt_q == sf_q);
    assign last_bit  = (bit_q == LAST_BIT);

`ifdef DCSK_TX_SAT_NEG_EN
    assign buf_neg = (buf_rd == S_MIN) ? S_MAX : -buf_rd;
`else
    assign buf_neg = -buf_rd;
`endif

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        sf_d        = sf_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_sample_d = tx_sample_q;
        tx_valid_d  = 1'b0;
        tx_ref_d    = 1'b0;
        Ready       = 1'b0;
        Chaos_Req   = 1'b0;

        case (state_q)
            StIdle: begin
                Ready = 1'b1;
                if (Valid) begin
                    word_d  = Data_In;
                    sf_d    = Spread_Factor;
                    cnt_d   = 5'd0;
                    bit_d   = '0;
                    state_d = StRef;
                end
            end

            StRef: begin
                Chaos_Req   = 1'b1;
                tx_sample_d = Chaos_Sample;
                tx_valid_d  = 1'b1;
                tx_ref_d    = 1'b1;
                if (half_done) begin
                    cnt_d   = 5'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            StData: begin
                tx_sample_d = cur_bit ? buf_rd : buf_neg;
                tx_valid_d  = 1'b1;
                if (half_done) begin
                    cnt_d = 5'd0;
                    if (last_bit) begin
                        // Accepting here lets the next word's reference follow with no gap.
                        Ready = 1'b1;
                        bit_d = '0;
                        if (Valid) begin
                            word_d  = Data_In;
                            sf_d    = Spread_Factor;
                            state_d = StRef;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = StRef;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) begin
            state_q     <= StIdle;
            word_q      <= '0;
            sf_q        <= 5'd0;
            cnt_q       <= 5'd0;
            bit_q       <= '0;
            tx_sample_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_ref_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            sf_q        <= sf_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_sample_q <= tx_sample_d;
            tx_valid_q  <= tx_valid_d;
            tx_ref_q    <= tx_ref_d;
        end
    end

    // Reference buffer holds no control state, so it is left unreset.
    always_ff @(posedge Clk) begin
        if (state_q == StRef) begin
            ref_buf[cnt_q] <= Chaos_Sample;
        end
    end

    assign Tx_Sample = tx_sample_q;
    assign Tx_Valid  = tx_valid_q;
    assign Tx_Ref    = tx_ref_q;

endmodule
